regfile_mp: RTL and testbench

- Next-generation CPU register file.
- Parametrised read-port and write-port counts.
- Arbitrary per-byte write masks and optional write-to-read bypass.
- Integrated per-register busy scoreboard so the issue stage detects RAW hazards on in-flight producers.
- Sits between decode/issue (read ports, scoreboard set) and writeback (write ports, scoreboard clear).

---
 rtl/regfile_mp_pkg.sv | 15 +
 rtl/regfile_mp_if.sv | 33 +++
 rtl/regfile_mp_merge.sv | 36 +++
 rtl/regfile_mp.sv | 126 ++++++++++++
 tb/tb_regfile_mp.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_mp_pkg.sv
// Shared constants, lane-count helper and address type for the multi-port register file.
package regfile_mp_pkg;

  localparam int REG_WORDS  = 32;
  localparam int REG_BITS   = 32;
  localparam int REG_NUM_RD = 2;
  localparam int REG_NUM_WR = 2;

  function automatic int lanes(input int bits);
    return bits / 8;
  endfunction

  typedef logic [$clog2(REG_WORDS)-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/scoreboard bundle between issue/writeback (master) and the register file (slave).
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int WORDS  = REG_WORDS,
  parameter int BITS   = REG_BITS,
  parameter int NUM_RD = REG_NUM_RD,
  parameter int NUM_WR = REG_NUM_WR,
  parameter int ADDR_W = $clog2(WORDS)
);
  localparam int LANES = lanes(BITS);

  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*BITS-1:0]   wr_data;
  logic [NUM_WR*LANES-1:0]  wr_be;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*BITS-1:0]   rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     sb_set_en;
  logic [ADDR_W-1:0]        sb_set_addr;
  logic [WORDS-1:0]         busy_vec;

  modport master (
    output wr_en, wr_addr, wr_data, wr_be, rd_addr, sb_set_en, sb_set_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_be, rd_addr, sb_set_en, sb_set_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_mp_merge.sv
// Per-byte priority merge of all write ports aimed at one address; highest port index wins.
module regfile_mp_merge #(
  parameter int NUM_WR = 2,
  parameter int BITS   = 32,
  parameter int ADDR_W = 5,
  parameter int LANES  = BITS / 8
) (
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*BITS-1:0]   wr_data_i,
  input  logic [NUM_WR*LANES-1:0]  wr_be_i,
  output logic [BITS-1:0]          data_o,
  output logic [LANES-1:0]         mask_o,
  output logic                     hit_o
);

  // Ascending scan: a later port overwrites an earlier one lane by lane.
  always_comb begin
    data_o = '0;
    mask_o = '0;
    hit_o  = 1'b0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (wr_en_i[k] && (wr_addr_i[k*ADDR_W +: ADDR_W] == addr_i)) begin
        hit_o = 1'b1;
        for (int b = 0; b < LANES; b++) begin
          if (wr_be_i[k*LANES + b]) begin
            data_o[b*8 +: 8] = wr_data_i[k*BITS + b*8 +: 8];
            mask_o[b]        = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with byte-masked writes, optional write-to-read bypass
// and a per-register busy scoreboard; reads are combinational.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int WORDS    = REG_WORDS,
  parameter int BITS     = REG_BITS,
  parameter int NUM_RD   = REG_NUM_RD,
  parameter int NUM_WR   = REG_NUM_WR,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  parameter int ADDR_W   = $clog2(WORDS)
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  rf
);

  localparam int LANES = lanes(BITS);

  logic [WORDS-1:0][BITS-1:0] mem_q, mem_d;
  logic [WORDS-1:0]           busy_q, busy_d;

  for (genvar r = 0; r < WORDS; r++) begin : g_reg
    localparam logic [ADDR_W-1:0] RA = ADDR_W'(r);

    if (ZERO_REG != 0 && r == 0) begin : g_zero
      assign mem_d[r]  = '0;
      assign busy_d[r] = 1'b0;
    end else begin : g_live
      logic [BITS-1:0]  m_data;
      logic [LANES-1:0] m_mask;
      logic             m_hit;
      logic             set;

      regfile_mp_merge #(
        .NUM_WR (NUM_WR),
        .BITS   (BITS),
        .ADDR_W (ADDR_W),
        .LANES  (LANES)
      ) u_wmerge (
        .addr_i    (RA),
        .wr_en_i   (rf.wr_en),
        .wr_addr_i (rf.wr_addr),
        .wr_data_i (rf.wr_data),
        .wr_be_i   (rf.wr_be),
        .data_o    (m_data),
        .mask_o    (m_mask),
        .hit_o     (m_hit)
      );

      always_comb begin
        mem_d[r] = mem_q[r];
        for (int b = 0; b < LANES; b++) begin
          if (m_mask[b]) mem_d[r][b*8 +: 8] = m_data[b*8 +: 8];
        end
      end

      // A new producer issued this cycle supersedes the writeback that retires the old one.
      assign set       = rf.sb_set_en && (rf.sb_set_addr == RA);
      assign busy_d[r] = set ? 1'b1 : (m_hit ? 1'b0 : busy_q[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  assign rf.busy_vec = busy_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              in_range;
    logic              is_zero;
    logic [BITS-1:0]   stored;
    logic [BITS-1:0]   merged;
    logic [BITS-1:0]   byp_data;
    logic [LANES-1:0]  byp_mask;
    logic              byp_hit;

    assign ra       = rf.rd_addr[p*ADDR_W +: ADDR_W];
    assign in_range = (32'(ra) < 32'(WORDS));
    assign is_zero  = (ZERO_REG != 0) && (ra == '0);
    assign stored   = in_range ? mem_q[ra] : '0;

    if (BYPASS != 0) begin : g_byp
      regfile_mp_merge #(
        .NUM_WR (NUM_WR),
        .BITS   (BITS),
        .ADDR_W (ADDR_W),
        .LANES  (LANES)
      ) u_bmerge (
        .addr_i    (ra),
        .wr_en_i   (rf.wr_en),
        .wr_addr_i (rf.wr_addr),
        .wr_data_i (rf.wr_data),
        .wr_be_i   (rf.wr_be),
        .data_o    (byp_data),
        .mask_o    (byp_mask),
        .hit_o     (byp_hit)
      );
    end else begin : g_nobyp
      assign byp_data = '0;
      assign byp_mask = '0;
      assign byp_hit  = 1'b0;
    end

    always_comb begin
      merged = stored;
      for (int b = 0; b < LANES; b++) begin
        if (byp_mask[b]) merged[b*8 +: 8] = byp_data[b*8 +: 8];
      end
    end

    // Reset gates the bypass too, so nothing leaks through while rst is high.
    assign rf.rd_data[p*BITS +: BITS] = (rst || is_zero || !in_range) ? '0 : merged;
    assign rf.rd_busy[p] = !rst && in_range && busy_q[ra] && !byp_hit;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench: a bypassing 32-entry instance and a non-bypassing 24-entry instance share stimulus.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.WORDS(32), .BITS(32), .NUM_RD(2), .NUM_WR(2)) ia ();
  regfile_mp_if #(.WORDS(24), .BITS(32), .NUM_RD(2), .NUM_WR(2)) ib ();

  assign ib.wr_en       = ia.wr_en;
  assign ib.wr_addr     = ia.wr_addr;
  assign ib.wr_data     = ia.wr_data;
  assign ib.wr_be       = ia.wr_be;
  assign ib.rd_addr     = ia.rd_addr;
  assign ib.sb_set_en   = ia.sb_set_en;
  assign ib.sb_set_addr = ia.sb_set_addr;

  regfile_mp #(.WORDS(32), .BITS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1))
    dut_a (.clk(clk), .rst(rst), .rf(ia));
  regfile_mp #(.WORDS(24), .BITS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(0), .ZERO_REG(1))
    dut_b (.clk(clk), .rst(rst), .rf(ib));

  typedef struct {
    logic [1:0]  wen;
    reg_addr_t   wa0, wa1;
    logic [31:0] wd0, wd1;
    logic [3:0]  be0, be1;
    reg_addr_t   ra0, ra1;
    logic [31:0] ea0, ea1;   // bypassing instance, same-cycle view
    logic [31:0] eb0, eb1;   // non-bypassing 24-entry instance
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    ia.wr_en       = '0;
    ia.wr_addr     = '0;
    ia.wr_data     = '0;
    ia.wr_be       = '0;
    ia.sb_set_en   = 1'b0;
    ia.sb_set_addr = '0;
  endtask

  task automatic wr(input int port, input reg_addr_t a, input logic [31:0] d, input logic [3:0] be);
    ia.wr_en[port]           = 1'b1;
    ia.wr_addr[port*5 +: 5]  = a;
    ia.wr_data[port*32 +: 32] = d;
    ia.wr_be[port*4 +: 4]    = be;
  endtask

  initial begin
    vt[0]  = '{2'b01, 5'd3,  5'd0,  32'hAABBCCDD, 32'h0, 4'hF, 4'h0, 5'd3,  5'd3,
               32'hAABBCCDD, 32'hAABBCCDD, 32'h0, 32'h0};
    vt[1]  = '{2'b01, 5'd3,  5'd0,  32'h11223344, 32'h0, 4'h5, 4'h0, 5'd3,  5'd5,
               32'hAA22CC44, 32'h0, 32'hAABBCCDD, 32'h0};
    vt[2]  = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 4'h0, 4'h0, 5'd3,  5'd3,
               32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44, 32'hAA22CC44};
    vt[3]  = '{2'b11, 5'd7,  5'd7,  32'h11111111, 32'h22222222, 4'hF, 4'h3, 5'd7,  5'd3,
               32'h11112222, 32'hAA22CC44, 32'h0, 32'hAA22CC44};
    vt[4]  = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 4'h0, 4'h0, 5'd7,  5'd0,
               32'h11112222, 32'h0, 32'h11112222, 32'h0};
    vt[5]  = '{2'b11, 5'd0,  5'd9,  32'hFFFFFFFF, 32'hDEADBEEF, 4'hF, 4'hF, 5'd0,  5'd9,
               32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    vt[6]  = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 4'h0, 4'h0, 5'd9,  5'd0,
               32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
    vt[7]  = '{2'b11, 5'd10, 5'd10, 32'h0000AB00, 32'hCD000000, 4'h2, 4'h8, 5'd10, 5'd9,
               32'hCD00AB00, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF};
    vt[8]  = '{2'b10, 5'd0,  5'd25, 32'h0, 32'h12345678, 4'h0, 4'hF, 5'd25, 5'd10,
               32'h12345678, 32'hCD00AB00, 32'h0, 32'hCD00AB00};
    vt[9]  = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 4'h0, 4'h0, 5'd25, 5'd10,
               32'h12345678, 32'hCD00AB00, 32'h0, 32'hCD00AB00};
    vt[10] = '{2'b11, 5'd11, 5'd11, 32'hAAAAAAAA, 32'hBBBBBBBB, 4'hF, 4'hF, 5'd11, 5'd25,
               32'hBBBBBBBB, 32'h12345678, 32'h0, 32'h0};
    vt[11] = '{2'b00, 5'd0,  5'd0,  32'h0, 32'h0, 4'h0, 4'h0, 5'd11, 5'd11,
               32'hBBBBBBBB, 32'hBBBBBBBB, 32'hBBBBBBBB, 32'hBBBBBBBB};

    // Reset: writes, sets and bypass must all be blocked
    rst = 1'b1;
    idle();
    wr(0, 5'd5, 32'hFFFFFFFF, 4'hF);
    ia.sb_set_en   = 1'b1;
    ia.sb_set_addr = 5'd5;
    ia.rd_addr     = {5'd5, 5'd5};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rd0", ia.rd_data[31:0], 32'h0);
    chk("rst_busy_port", 32'(ia.rd_busy), 32'h0);
    chk("rst_busy_vec", ia.busy_vec, 32'h0);
    rst = 1'b0;
    idle();
    #1;
    chk("post_rst_rd0", ia.rd_data[31:0], 32'h0);
    chk("post_rst_rd1", ia.rd_data[63:32], 32'h0);
    @(negedge clk);
    #2;
    chk("post_rst_r5_edge", ia.rd_data[31:0], 32'h0);
    chk("post_rst_busy_vec", ia.busy_vec, 32'h0);

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ia.wr_en   = vt[i].wen;
      ia.wr_addr = {vt[i].wa1, vt[i].wa0};
      ia.wr_data = {vt[i].wd1, vt[i].wd0};
      ia.wr_be   = {vt[i].be1, vt[i].be0};
      ia.rd_addr = {vt[i].ra1, vt[i].ra0};
      #2;
      chk($sformatf("vec%0d_a_rd0", i), ia.rd_data[31:0],  vt[i].ea0);
      chk($sformatf("vec%0d_a_rd1", i), ia.rd_data[63:32], vt[i].ea1);
      chk($sformatf("vec%0d_b_rd0", i), ib.rd_data[31:0],  vt[i].eb0);
      chk($sformatf("vec%0d_b_rd1", i), ib.rd_data[63:32], vt[i].eb1);
    end

    // Scoreboard set / clear / set-wins
    @(negedge clk);
    idle();
    ia.sb_set_en   = 1'b1;
    ia.sb_set_addr = 5'd4;
    ia.rd_addr     = {5'd4, 5'd4};
    #2;
    chk("sb_same_cycle_rd_busy", 32'(ia.rd_busy[0]), 32'h0);
    @(negedge clk);
    idle();
    #2;
    chk("sb_set_busy_vec_a", ia.busy_vec, 32'h00000010);
    chk("sb_set_busy_vec_b", 32'(ib.busy_vec), 32'h00000010);
    chk("sb_set_rd_busy_a", 32'(ia.rd_busy[0]), 32'h1);
    @(negedge clk);
    wr(0, 5'd4, 32'hFFFFFFFF, 4'h0);
    #2;
    chk("sb_clr_bypass_rd_busy_a", 32'(ia.rd_busy[0]), 32'h0);
    chk("sb_clr_nobypass_rd_busy_b", 32'(ib.rd_busy[0]), 32'h1);
    chk("be0_write_data_a", ia.rd_data[31:0], 32'h0);
    @(negedge clk);
    idle();
    #2;
    chk("sb_clr_busy_vec_a", ia.busy_vec, 32'h0);
    chk("sb_clr_busy_vec_b", 32'(ib.busy_vec), 32'h0);
    chk("be0_r4_kept", ia.rd_data[31:0], 32'h0);
    @(negedge clk);
    ia.sb_set_en   = 1'b1;
    ia.sb_set_addr = 5'd4;
    wr(1, 5'd4, 32'h00000055, 4'h1);
    @(negedge clk);
    idle();
    #2;
    chk("sb_set_and_clr_busy_vec", ia.busy_vec, 32'h00000010);
    chk("sb_set_and_clr_rd_busy", 32'(ia.rd_busy[0]), 32'h1);
    chk("sb_set_and_clr_data", ia.rd_data[31:0], 32'h00000055);

    // r0 never busy; out-of-range set ignored by the 24-entry instance
    @(negedge clk);
    ia.sb_set_en   = 1'b1;
    ia.sb_set_addr = 5'd0;
    @(negedge clk);
    ia.sb_set_addr = 5'd30;
    ia.rd_addr     = {5'd0, 5'd30};
    @(negedge clk);
    idle();
    #2;
    chk("sb_r0_r30_busy_vec_a", ia.busy_vec, 32'h40000010);
    chk("sb_r30_busy_vec_b", 32'(ib.busy_vec), 32'h00000010);
    chk("sb_r30_rd_busy_a", 32'(ia.rd_busy[0]), 32'h1);
    chk("sb_r30_rd_busy_b", 32'(ib.rd_busy[0]), 32'h0);
    chk("sb_r0_rd_busy_a", 32'(ia.rd_busy[1]), 32'h0);

    // Asynchronous reset pulse between clock edges
    @(negedge clk);
    ia.rd_addr = {5'd11, 5'd3};
    #1;
    chk("pre_arst_r3", ia.rd_data[31:0], 32'hAA22CC44);
    #1 rst = 1'b1;
    #1;
    chk("arst_r3_a", ia.rd_data[31:0], 32'h0);
    chk("arst_r11_b", ib.rd_data[63:32], 32'h0);
    chk("arst_busy_vec_a", ia.busy_vec, 32'h0);
    chk("arst_busy_vec_b", 32'(ib.busy_vec), 32'h0);
    #1 rst = 1'b0;
    @(negedge clk);
    #2;
    chk("after_arst_r3", ia.rd_data[31:0], 32'h0);
    chk("after_arst_r11", ia.rd_data[63:32], 32'h0);
    chk("after_arst_busy_vec", ia.busy_vec, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
